// File: rtl/eth_tx_arb_pkg.sv
// Shared types for the Ethernet TX frame arbiter: AXIS payloads, FSM states
// and the beat used to terminate a stalled frame toward the MAC.
package eth_tx_arb_pkg;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [0:0] user;
    } axis_beat_t;

    typedef struct packed {
        logic       tvalid;
        axis_beat_t t;
    } axi_stream_req_t;

    typedef struct packed {
        logic tready;
    } axi_stream_rsp_t;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        ABORT,
        FLUSH
    } arb_state_t;

    localparam axi_stream_req_t AbortBeat = '{
        tvalid: 1'b1,
        t: '{data: 8'h00, last: 1'b1, user: 1'b1}
    };

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Rotate-priority pick: first set request at or after ptr, wrapping at N.
module rr_arb_pick
    import eth_tx_arb_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = idx_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    onehot,
    output logic [IdxW-1:0] idx,
    output logic            valid
);

    localparam int unsigned PosW = IdxW + 1;

    logic [PosW-1:0] pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        pos    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + PosW'(i);
            if (pos >= PosW'(N)) begin
                pos = pos - PosW'(N);
            end
            if (!valid && req[pos[IdxW-1:0]]) begin
                valid                  = 1'b1;
                idx                    = pos[IdxW-1:0];
                onehot[pos[IdxW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-level round-robin arbiter in front of the framing block's TX AXIS port,
// with mid-frame stall detection, abort beat insertion and frame flushing.
module eth_tx_frame_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int unsigned NumReq       = 4,
    parameter int unsigned StallTimeout = 256,
    parameter int unsigned CntWidth     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  axi_stream_req_t       req_axis_req_i [NumReq],
    output axi_stream_rsp_t       req_axis_rsp_o [NumReq],
    output axi_stream_req_t       tx_axis_req_o,
    input  axi_stream_rsp_t       tx_axis_rsp_i,
    input  logic [NumReq-1:0]     req_en_i,
    output logic [NumReq-1:0]     grant_o,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic [CntWidth-1:0]   abort_cnt_o
);

    localparam int unsigned IdxW      = idx_width(NumReq);
    localparam int unsigned StallW    = (StallTimeout > 1) ? $clog2(StallTimeout) : 1;
    localparam int unsigned StallMax  = (StallTimeout > 0) ? StallTimeout - 1 : 0;
    localparam bit          TimeoutEn = (StallTimeout != 0);

    arb_state_t        state;
    logic [IdxW-1:0]   gnt_idx;
    logic [IdxW-1:0]   ptr;
    logic [StallW-1:0] stall_cnt;

    axi_stream_req_t   sel;
    logic [NumReq-1:0] cand;
    logic [NumReq-1:0] pick_onehot;
    logic [IdxW-1:0]   pick_idx;
    logic              pick_valid;
    logic              stall_hit;

    // Candidates for the next grant and the currently granted request.
    always_comb begin
        cand = '0;
        sel  = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand[i] = req_axis_req_i[i].tvalid & req_en_i[i];
            if (IdxW'(i) == gnt_idx) begin
                sel = req_axis_req_i[i];
            end
        end
    end

    rr_arb_pick #(
        .N    (NumReq),
        .IdxW (IdxW)
    ) u_pick (
        .req    (cand),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign stall_hit = TimeoutEn && !sel.tvalid && (stall_cnt == StallW'(StallMax));

    // Data path is combinational so a granted frame streams at full rate.
    always_comb begin
        tx_axis_req_o = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            req_axis_rsp_o[i] = '0;
        end
        case (state)
            PASS: begin
                tx_axis_req_o = sel;
                for (int unsigned i = 0; i < NumReq; i++) begin
                    if (IdxW'(i) == gnt_idx) begin
                        req_axis_rsp_o[i].tready = tx_axis_rsp_i.tready;
                    end
                end
            end
            ABORT: tx_axis_req_o = AbortBeat;
            FLUSH: begin
                for (int unsigned i = 0; i < NumReq; i++) begin
                    if (IdxW'(i) == gnt_idx) begin
                        req_axis_rsp_o[i].tready = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            gnt_idx      <= '0;
            ptr          <= '0;
            stall_cnt    <= '0;
            grant_o      <= '0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            abort_cnt_o  <= '0;
        end else begin
            frame_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    if (pick_valid) begin
                        state   <= PASS;
                        gnt_idx <= pick_idx;
                        grant_o <= pick_onehot;
                        busy_o  <= 1'b1;
                        ptr     <= (pick_idx == IdxW'(NumReq - 1)) ? '0 : pick_idx + IdxW'(1);
                    end
                end
                PASS: begin
                    if (sel.tvalid) begin
                        stall_cnt <= '0;
                        if (tx_axis_rsp_i.tready && sel.t.last) begin
                            state        <= IDLE;
                            grant_o      <= '0;
                            busy_o       <= 1'b0;
                            frame_done_o <= 1'b1;
                        end
                    end else if (stall_hit) begin
                        state <= ABORT;
                    end else begin
                        stall_cnt <= stall_cnt + StallW'(1);
                    end
                end
                ABORT: begin
                    if (tx_axis_rsp_i.tready) begin
                        state <= FLUSH;
                        if (abort_cnt_o != '1) begin
                            abort_cnt_o <= abort_cnt_o + CntWidth'(1);
                        end
                    end
                end
                FLUSH: begin
                    // Beats from the stalled requester are swallowed up to its tlast.
                    if (sel.tvalid && sel.t.last) begin
                        state        <= IDLE;
                        grant_o      <= '0;
                        busy_o       <= 1'b0;
                        frame_done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
